// File: rtl/sos_decode_if.sv
// sos_decode_if: start/done control, Morse line and letter report of the SOS decoder
interface sos_decode_if;
  logic       start_sig;
  logic       pin_in;
  logic       done_sig;
  logic       err_sig;
  logic       letter_valid;
  logic [1:0] letter_id;
  modport master(output start_sig, pin_in, input done_sig, err_sig, letter_valid, letter_id);
  modport slave(input start_sig, pin_in, output done_sig, err_sig, letter_valid, letter_id);
endinterface

// File: rtl/sos_decode_module.sv
// sos_decode_module: times marks/spaces on a Morse line, decodes letters and flags each S-O-S
module sos_decode_module #(
  parameter int T_UNIT = 5000000,
  parameter int GLITCH = T_UNIT / 4,
  parameter int CNT_W  = 26
) (
  input logic       clk,
  input logic       rst_n,
  sos_decode_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SPACE = 2'd1, ST_MARK = 2'd2;
  localparam logic [1:0] SQ_NONE = 2'd0, SQ_S = 2'd1, SQ_SO = 2'd2;
  localparam logic [1:0] LT_S = 2'd0, LT_O = 2'd1, LT_X = 2'd2;
  localparam logic [CNT_W-1:0] C_GL   = CNT_W'(GLITCH);
  localparam logic [CNT_W-1:0] C_2U   = CNT_W'(2 * T_UNIT);
  localparam logic [CNT_W-1:0] C_4U   = CNT_W'(4 * T_UNIT);
  localparam logic [CNT_W-1:0] C_5U   = CNT_W'(5 * T_UNIT);
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(6 * T_UNIT);

  logic [1:0]       sync_q;
  logic [1:0]       state_q, state_d, seq_q, seq_d, id_q, id_d, cur_id;
  logic [CNT_W-1:0] space_q, space_d, mark_q, mark_d;
  logic [2:0]       bits_q, bits_d, sym_q, sym_d;
  logic             done_q, done_d, err_q, err_d, lv_q, lv_d, p, close;

  assign p      = sync_q[1];
  assign close  = state_q == ST_SPACE && space_q == C_2U && sym_q != 3'd0;
  assign cur_id = sym_q == 3'd3 && bits_q == 3'b000 ? LT_S :
                  sym_q == 3'd3 && bits_q == 3'b111 ? LT_O : LT_X;

  always_comb begin
    state_d = state_q;
    space_d = space_q;
    mark_d  = mark_q;
    bits_d  = bits_q;
    sym_d   = sym_q;
    seq_d   = seq_q;
    id_d    = id_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lv_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (p) begin
        state_d = ST_SPACE;
        space_d = '0;
      end
      ST_SPACE: begin
        // the letter closes before a coincident mark is taken, so that mark opens a fresh letter
        if (close) begin
          lv_d   = 1'b1;
          id_d   = cur_id;
          bits_d = '0;
          sym_d  = '0;
          done_d = seq_q == SQ_SO && cur_id == LT_S;
          seq_d  = cur_id == LT_S ? (seq_q == SQ_SO ? SQ_NONE : SQ_S) :
                   cur_id == LT_O && seq_q == SQ_S ? SQ_SO : SQ_NONE;
        end
        if (space_q == C_5U) seq_d = SQ_NONE;
        if (p) space_d = space_q == C_SAT ? space_q : space_q + 1'b1;
        else begin
          state_d = ST_MARK;
          mark_d  = CNT_W'(1);
        end
      end
      ST_MARK: if (!p) mark_d = mark_q == C_SAT ? mark_q : mark_q + 1'b1;
      else begin
        state_d = ST_SPACE;
        space_d = '0;
        if (mark_q > C_4U) begin
          err_d  = 1'b1;
          bits_d = '0;
          sym_d  = '0;
          seq_d  = SQ_NONE;
        end else if (mark_q >= C_GL) begin
          bits_d = {bits_q[1:0], mark_q >= C_2U};
          sym_d  = sym_q == 3'd7 ? sym_q : sym_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sync_q <= rst_n ? {sync_q[0], bus.pin_in} : 2'b11;
    if (!rst_n || !bus.start_sig) begin
      state_q <= ST_IDLE;
      space_q <= '0;
      mark_q  <= '0;
      bits_q  <= '0;
      sym_q   <= '0;
      seq_q   <= SQ_NONE;
      id_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      mark_q  <= mark_d;
      bits_q  <= bits_d;
      sym_q   <= sym_d;
      seq_q   <= seq_d;
      id_q    <= id_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lv_q    <= lv_d;
    end
  end

  assign bus.done_sig     = done_q;
  assign bus.err_sig      = err_q;
  assign bus.letter_valid = lv_q;
  assign bus.letter_id    = id_q;
endmodule

// File: doc/sos_decode_module.md
Name: sos_decode_module

Overview:
- Receive-side counterpart of the SOS Morse generator: samples a single Morse line (idle high, active low), measures mark/space durations and classifies dots and dashes.
- Assembles symbols into letters and recognises the letter sequence S-O-S.
- Pulses done_sig on each complete SOS, with a start_sig/done_sig handshake matching the other control-style modules.
- Used for loopback self-test of the generator's pin_out, or for decoding a push-key input.

Parameters:
- T_UNIT, 5000000: Morse unit length in clk cycles (100 ms at 50 MHz).
- GLITCH, T_UNIT/4: marks shorter than this many cycles are discarded as noise.
- CNT_W, 26: duration counter width; must hold 6*T_UNIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- start_sig  input  1  level enable; 0 holds the block cleared
- pin_in  input  1  Morse line, asynchronous; 1 = idle/space, 0 = mark
- done_sig  output  1  one-cycle pulse when S-O-S completes
- err_sig  output  1  one-cycle pulse on an over-long mark
- letter_valid  output  1  one-cycle pulse when a letter is closed
- letter_id  output  2  valid with letter_valid: 0 = S, 1 = O, 2 = other

Behaviour:
- Reset and clock: one clock (clk). rst_n is synchronous and active-low. On rst_n=0 at a clk edge, every register clears: FSM = IDLE, counters = 0, symbol buffer empty, seq = NONE, all outputs 0. Reset mid-letter discards the partial letter; no pulse is emitted.
- Input sync: pin_in passes through a 2-flop synchronizer preset to 1; all decisions use the synced value p. Input-to-decision latency is 2 cycles.
- start_sig = 0: same clearing effect as reset, evaluated every cycle; p is ignored.
- IDLE state: wait for p=1, then go to SPACE with space_cnt = 0. This prevents decoding a mark that is already in progress.
- SPACE state:
  - p=1: space_cnt increments, saturating at 6*T_UNIT.
  - p=0: go to MARK with mark_cnt = 1.
  - space_cnt reaches 2*T_UNIT with sym_cnt > 0: close the letter. letter_valid = 1 for 1 cycle, letter_id set, buffer cleared.
  - space_cnt reaches 5*T_UNIT: seq is forced to NONE (word gap). No pulse.
- MARK state:
  - p=0: mark_cnt increments, saturating at 6*T_UNIT.
  - p=1: classify the mark, go to SPACE with space_cnt = 0.
    - mark_cnt < GLITCH: discard the mark; buffer unchanged.
    - GLITCH <= mark_cnt < 2*T_UNIT: dot; shift 0 into the buffer.
    - 2*T_UNIT <= mark_cnt <= 4*T_UNIT: dash; shift 1 into the buffer.
    - mark_cnt > 4*T_UNIT: err_sig = 1 for 1 cycle; buffer cleared; seq = NONE.
- Symbol buffer: 3-bit shift register plus sym_cnt, saturating at 7.
  - Letter = S only if sym_cnt == 3 and bits == 000.
  - Letter = O only if sym_cnt == 3 and bits == 111.
  - Anything else = other.
- Sequence tracker, applied on each letter_valid:
  - NONE: S goes to GOT_S; O or other stays NONE.
  - GOT_S: O goes to GOT_SO; S stays GOT_S; other goes to NONE.
  - GOT_SO: S asserts done_sig in the same cycle as that letter_valid, then seq goes to NONE; O or other goes to NONE.
- Boundary rules:
  - Back-to-back SOS transmissions separated by a letter gap yield one done_sig each.
  - SOSOS yields exactly one done_sig; there is no overlap reuse.
  - A mark arriving in the same cycle space_cnt hits 2*T_UNIT: the letter is closed first, and the mark starts a new letter.
- Output registers: all outputs are registered; pulses never exceed 1 cycle.

Test Plan:
(Bench parameters: T_UNIT = 10, GLITCH = 2. Dot = 10 cycles low, dash = 30 cycles low, intra-letter gap = 10 high, letter gap = 30 high.)
- Clean SOS (...---...), then 60 high -> letter_valid ×3 with ids 0,1,0; one done_sig coincident with the third letter_valid; err_sig never asserted.
- Glitch rejection: 1-cycle low pulses inserted in every gap of an SOS -> identical result to the clean case, exactly one done_sig.
- Long mark: 50-cycle low, then SOS -> err_sig one pulse at the mark release; done_sig after the following SOS.
- Wrong letter: S, then E (one dot), then S -> ids 0,2,0; no done_sig.
- Word-gap and enable: S, O, then 60 high, then S -> no done_sig. Separately, drop start_sig mid-O, re-raise it, send SOS -> exactly one done_sig.
- Synchronous reset: assert rst_n=0 for 1 cycle during the second S of an SOS -> outputs 0 from the next edge; no letter_valid for the partial letter; no done_sig.
